branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
Parametrised successor to the ID-stage branch decision logic. Adds three things:
- Full RV64 conditional-branch resolution: BEQ, BNE, BLT, BGE, BLTU, BGEU.
- A direct-mapped table of 2-bit saturating counters plus a branch target buffer (BTB), looked up in IF.
- Misprediction detection and redirect generation, with performance counters.

Lookup is in the IF stage; resolution and update are in the ID stage.

Parameters:
XLEN, 64, data and PC width.
BHT_DEPTH, 64, number of table entries; power of two, ≥2.
CNT_W, 32, width of each performance counter.
(localparam) IDX_W = $clog2(BHT_DEPTH); TAG_W = XLEN-IDX_W-2.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
if_pc  in  XLEN  fetch PC for lookup
pred_taken  out  1  IF prediction: taken
pred_target  out  XLEN  IF predicted target (if_pc+4 when not taken)
res_valid  in  1  ID holds a conditional branch this cycle
res_stall  in  1  ID stalled; suppresses resolution side-effects
res_pc  in  XLEN  PC of the branch in ID
res_imm  in  XLEN  sign-extended B-immediate
res_funct3  in  3  branch type
rs1_data  in  XLEN  forwarded operand 1
rs2_data  in  XLEN  forwarded operand 2
res_pred_taken  in  1  prediction carried down with the instruction
res_pred_target  in  XLEN  predicted target carried down with the instruction
take_branch  out  1  actual outcome
branch_target  out  XLEN  res_pc+res_imm
mispredict  out  1  redirect required
redirect_pc  out  XLEN  correct next PC
illegal_branch  out  1  res_valid with funct3 ∈ {010,011}
branch_count  out  CNT_W  resolved branches
mispredict_count  out  CNT_W  mispredictions

Behaviour:
- Reset (async, any cycle including mid-update):
  - All counters go to 2'b01 (weakly not-taken); all BTB valid bits clear.
  - branch_count and mispredict_count go to 0.
  - Combinational outputs follow from the cleared state: pred_taken=0, pred_target=if_pc+4.
- Indexing: idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
- Lookup (combinational, 0 latency):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && cnt[idx][1].
  - pred_target = pred_taken ? btb_target[idx] : if_pc+4.
- Resolution (combinational, same cycle, active when act = res_valid && !res_stall):
  - Compare rules: 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - Illegal funct3 gives take_branch=0 and illegal_branch=1.
  - All additions are modulo 2^XLEN; wrap-around is silently accepted.
  - mispredict = act && !illegal && (take_branch != res_pred_taken || (take_branch && res_pred_target != branch_target)).
  - redirect_pc = take_branch ? branch_target : res_pc+4.
  - When act=0: take_branch, mispredict and illegal_branch are all 0.
- Update (registered, on the clock edge after resolution, only when act && !illegal):
  - cnt[ridx] increments (saturating at 11) on taken, decrements (saturating at 00) on not taken.
  - If taken: valid[ridx]=1, tag written, btb_target=branch_target. A different tag overwrites the entry; its counter is not reset.
  - If not taken, the BTB entry is unchanged.
- Stats: branch_count +1 per update; mispredict_count +1 when mispredict. Both saturate at all-ones, no wrap.
- Same-cycle lookup and update to the same idx: lookup returns the pre-update value; the new value is visible the next cycle.
- res_stall=1 holds for multiple cycles: no update and no counting, even if inputs stay valid.
- No $display in synthesizable paths.

Test Plan:
1. Reset, then if_pc=0x100 → pred_taken=0, pred_target=0x104; counts=0.
2. BEQ at res_pc=0x100, imm=0x20, rs1=rs2=5, pred=0 → take_branch=1, mispredict=1, redirect_pc=0x120. Next cycle, if_pc=0x100 gives pred_taken=1, pred_target=0x120.
3. Signed vs unsigned compare with rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1:
   - BLT → taken.
   - BLTU → not taken.
   - BGEU → taken.
   - BGE → not taken.
4. Saturation: the same taken branch resolved 4× → counter holds 11. Then 1 not-taken → pred still taken (10). A 2nd not-taken → pred not-taken.
5. Aliasing: with BHT_DEPTH=64, 0x100 and 0x200 share idx 0. Taken update from 0x200 → lookup at 0x100 gives tag miss, pred_taken=0.
6. Edge cases:
   - res_stall=1 for 3 cycles → counts unchanged.
   - funct3=010 → illegal_branch=1, no update.
   - reset asserted mid-sequence → all state cleared immediately.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Branch predictor and resolver.
// A direct-mapped table of 2-bit counters with a tagged BTB is looked up in IF.
// Conditional branches are resolved in ID. The resolver flags mispredictions,
// produces the redirect PC, trains the table and keeps saturating statistics.
module branch_predict_unit #(
   parameter int XLEN      = 64,
   parameter int BHT_DEPTH = 64,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  if_pc,
   output logic             pred_taken,
   output logic [XLEN-1:0]  pred_target,
   input  logic             res_valid,
   input  logic             res_stall,
   input  logic [XLEN-1:0]  res_pc,
   input  logic [XLEN-1:0]  res_imm,
   input  logic [2:0]       res_funct3,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic [XLEN-1:0]  rs2_data,
   input  logic             res_pred_taken,
   input  logic [XLEN-1:0]  res_pred_target,
   output logic             take_branch,
   output logic [XLEN-1:0]  branch_target,
   output logic             mispredict,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             illegal_branch,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);
   localparam int IDX_W = $clog2(BHT_DEPTH);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic [1:0]           cnt_vec [BHT_DEPTH];
   logic [BHT_DEPTH-1:0] valid_vec;
   logic [TAG_W-1:0]     tag_mem [BHT_DEPTH];
   logic [XLEN-1:0]      target_mem [BHT_DEPTH];

   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic             hit;
   logic [IDX_W-1:0] ridx;
   logic [TAG_W-1:0] rtag;
   logic             act;
   logic             upd;
   logic             cond;
   logic             illegal;

   // Lookup: plain combinational read, so a same-cycle update is not yet visible
   assign if_idx      = if_pc[IDX_W+1:2];
   assign if_tag      = if_pc[XLEN-1:IDX_W+2];
   assign hit         = valid_vec[if_idx] && (tag_mem[if_idx] == if_tag);
   assign pred_taken  = hit && cnt_vec[if_idx][1];
   assign pred_target = pred_taken ? target_mem[if_idx] : if_pc + XLEN'(4);

   // Compare rules by funct3; 010 and 011 are not branch encodings
   always_comb begin
      cond    = 1'b0;
      illegal = 1'b0;
      case (res_funct3)
         3'b000:  cond = (rs1_data == rs2_data);
         3'b001:  cond = (rs1_data != rs2_data);
         3'b100:  cond = ($signed(rs1_data) <  $signed(rs2_data));
         3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
         3'b110:  cond = (rs1_data <  rs2_data);
         3'b111:  cond = (rs1_data >= rs2_data);
         default: illegal = 1'b1;
      endcase
   end

   // A stalled ID stage produces no outcome, no redirect and no training
   assign act            = res_valid && !res_stall;
   assign upd            = act && !illegal;
   assign take_branch    = upd && cond;
   assign illegal_branch = act && illegal;
   assign branch_target  = res_pc + res_imm;
   assign mispredict     = upd && ((take_branch != res_pred_taken) ||
                                   (take_branch && (res_pred_target != branch_target)));
   assign redirect_pc    = take_branch ? branch_target : res_pc + XLEN'(4);
   assign ridx           = res_pc[IDX_W+1:2];
   assign rtag           = res_pc[XLEN-1:IDX_W+2];

   // One counter and valid bit per entry; both are cleared by reset
   for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_entry
      logic [1:0] cnt_reg;
      logic [1:0] cnt_next;
      logic       valid_reg;
      logic       wr_en;

      assign wr_en = upd && (ridx == IDX_W'(gi));

      // Saturating step toward the resolved direction
      always_comb begin
         cnt_next = cnt_reg;
         if (take_branch) begin
            if (cnt_reg != 2'b11) cnt_next = cnt_reg + 2'b01;
         end else if (cnt_reg != 2'b00) begin
            cnt_next = cnt_reg - 2'b01;
         end
      end

      // Train the entry. A taken branch claims the slot; the counter is kept on a tag change.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt_reg   <= 2'b01;
            valid_reg <= 1'b0;
         end else if (wr_en) begin
            cnt_reg <= cnt_next;
            if (take_branch) valid_reg <= 1'b1;
         end
      end

      assign cnt_vec[gi]   = cnt_reg;
      assign valid_vec[gi] = valid_reg;
   end

   // Tag and target storage; the valid bits alone decide whether an entry counts
   always_ff @(posedge clk) begin
      if (!reset && take_branch) begin
         tag_mem[ridx]    <= rtag;
         target_mem[ridx] <= branch_target;
      end
   end

   // Statistics counters that stick at all-ones instead of wrapping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (upd) begin
         if (branch_count != {CNT_W{1'b1}}) branch_count <= branch_count + CNT_W'(1);
         if (mispredict && (mispredict_count != {CNT_W{1'b1}}))
            mispredict_count <= mispredict_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit. The statistics counters are narrowed
// to 4 bits so that their saturation can be reached.
module tb_branch_predict_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] if_pc;
   logic        pred_taken;
   logic [63:0] pred_target;
   logic        res_valid, res_stall;
   logic [63:0] res_pc, res_imm;
   logic [2:0]  res_funct3;
   logic [63:0] rs1_data, rs2_data;
   logic        res_pred_taken;
   logic [63:0] res_pred_target;
   logic        take_branch;
   logic [63:0] branch_target;
   logic        mispredict;
   logic [63:0] redirect_pc;
   logic        illegal_branch;
   logic [3:0]  branch_count, mispredict_count;

   int checks = 0;
   int passed = 0;

   branch_predict_unit #(.XLEN(64), .BHT_DEPTH(64), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken),
      .pred_target(pred_target), .res_valid(res_valid), .res_stall(res_stall),
      .res_pc(res_pc), .res_imm(res_imm), .res_funct3(res_funct3),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .res_pred_taken(res_pred_taken),
      .res_pred_target(res_pred_target), .take_branch(take_branch),
      .branch_target(branch_target), .mispredict(mispredict),
      .redirect_pc(redirect_pc), .illegal_branch(illegal_branch),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_branch(input logic [63:0] pc, input logic [63:0] imm,
                               input logic [2:0] f3, input logic [63:0] a,
                               input logic [63:0] b, input logic pt,
                               input logic [63:0] ptgt);
      res_valid = 1'b1; res_stall = 1'b0; res_pc = pc; res_imm = imm;
      res_funct3 = f3; rs1_data = a; rs2_data = b;
      res_pred_taken = pt; res_pred_target = ptgt;
      $display("branch pc=%h imm=%h f3=%b rs1=%h rs2=%h pred=%0b", pc, imm, f3, a, b, pt);
   endtask

   task automatic idle();
      res_valid = 1'b0; res_stall = 1'b0;
   endtask

   task automatic test_reset();
      if_pc = 64'h100; #1;
      checks++; if (pred_taken !== 1'b0) $display("FAIL reset_pred: got %0b want 0", pred_taken); else passed++;
      checks++; if (pred_target !== 64'h104) $display("FAIL reset_target: got %h want 104", pred_target); else passed++;
      checks++; if (branch_count !== 4'd0) $display("FAIL reset_bcnt: got %0d want 0", branch_count); else passed++;
      checks++; if (mispredict_count !== 4'd0) $display("FAIL reset_mcnt: got %0d want 0", mispredict_count); else passed++;
   endtask

   task automatic test_beq();
      if_pc = 64'h100;
      drive_branch(64'h100, 64'h20, 3'b000, 64'd5, 64'd5, 1'b0, 64'h0); #1;
      checks++; if (take_branch !== 1'b1) $display("FAIL beq_take: got %0b want 1", take_branch); else passed++;
      checks++; if (mispredict !== 1'b1) $display("FAIL beq_mispredict: got %0b want 1", mispredict); else passed++;
      checks++; if (redirect_pc !== 64'h120) $display("FAIL beq_redirect: got %h want 120", redirect_pc); else passed++;
      checks++; if (pred_taken !== 1'b0) $display("FAIL beq_same_cycle_lookup: got %0b want 0", pred_taken); else passed++;
      step(); idle(); #1;
      checks++; if (pred_taken !== 1'b1) $display("FAIL beq_next_pred: got %0b want 1", pred_taken); else passed++;
      checks++; if (pred_target !== 64'h120) $display("FAIL beq_next_target: got %h want 120", pred_target); else passed++;
      checks++; if (branch_count !== 4'd1 || mispredict_count !== 4'd1)
         $display("FAIL beq_counts: got %0d/%0d want 1/1", branch_count, mispredict_count); else passed++;
   endtask

   task automatic test_compare();
      logic [2:0] f3s [4]  = '{3'b100, 3'b110, 3'b111, 3'b101};
      logic       exps [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 4; k++) begin
         logic [63:0] pc;
         pc = 64'h10 + 64'(4 * k);
         drive_branch(pc, 64'h40, f3s[k], 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, exps[k], pc + 64'h40); #1;
         checks++; if (take_branch !== exps[k]) $display("FAIL cmp_take f3=%b: got %0b want %0b", f3s[k], take_branch, exps[k]); else passed++;
         checks++; if (mispredict !== 1'b0) $display("FAIL cmp_mispredict f3=%b: got %0b want 0", f3s[k], mispredict); else passed++;
         step();
      end
      idle(); #1;
      checks++; if (branch_count !== 4'd5 || mispredict_count !== 4'd1)
         $display("FAIL cmp_counts: got %0d/%0d want 5/1", branch_count, mispredict_count); else passed++;
   endtask

   task automatic test_saturation();
      if_pc = 64'h80;
      for (int k = 0; k < 4; k++) begin
         drive_branch(64'h80, 64'h10, 3'b000, 64'd7, 64'd7, 1'b1, 64'h90);
         step();
      end
      idle(); #1;
      checks++; if (pred_taken !== 1'b1 || pred_target !== 64'h90)
         $display("FAIL sat_strong: got %0b/%h want 1/90", pred_taken, pred_target); else passed++;
      drive_branch(64'h80, 64'h10, 3'b001, 64'd7, 64'd7, 1'b1, 64'h90); #1;
      checks++; if (mispredict !== 1'b1 || redirect_pc !== 64'h84)
         $display("FAIL sat_nt_redirect: got %0b/%h want 1/84", mispredict, redirect_pc); else passed++;
      step(); idle(); #1;
      checks++; if (pred_taken !== 1'b1) $display("FAIL sat_weak_taken: got %0b want 1", pred_taken); else passed++;
      drive_branch(64'h80, 64'h10, 3'b001, 64'd7, 64'd7, 1'b1, 64'h90);
      step(); idle(); #1;
      checks++; if (pred_taken !== 1'b0 || pred_target !== 64'h84)
         $display("FAIL sat_not_taken: got %0b/%h want 0/84", pred_taken, pred_target); else passed++;
      checks++; if (branch_count !== 4'd11 || mispredict_count !== 4'd3)
         $display("FAIL sat_counts: got %0d/%0d want 11/3", branch_count, mispredict_count); else passed++;
   endtask

   task automatic test_alias();
      drive_branch(64'h200, 64'h40, 3'b000, 64'd1, 64'd1, 1'b1, 64'h240);
      step(); idle();
      if_pc = 64'h100; #1;
      checks++; if (pred_taken !== 1'b0 || pred_target !== 64'h104)
         $display("FAIL alias_miss: got %0b/%h want 0/104", pred_taken, pred_target); else passed++;
      if_pc = 64'h200; #1;
      checks++; if (pred_taken !== 1'b1 || pred_target !== 64'h240)
         $display("FAIL alias_hit: got %0b/%h want 1/240", pred_taken, pred_target); else passed++;
      checks++; if (branch_count !== 4'd12 || mispredict_count !== 4'd3)
         $display("FAIL alias_counts: got %0d/%0d want 12/3", branch_count, mispredict_count); else passed++;
   endtask

   task automatic test_stall();
      drive_branch(64'h40, 64'h8, 3'b000, 64'd2, 64'd2, 1'b0, 64'h0);
      res_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (take_branch !== 1'b0 || mispredict !== 1'b0)
            $display("FAIL stall_outputs cycle %0d: got %0b/%0b want 0/0", k, take_branch, mispredict); else passed++;
         step();
      end
      idle(); #1;
      checks++; if (branch_count !== 4'd12 || mispredict_count !== 4'd3)
         $display("FAIL stall_counts: got %0d/%0d want 12/3", branch_count, mispredict_count); else passed++;
   endtask

   task automatic test_illegal();
      drive_branch(64'h200, 64'h40, 3'b010, 64'd1, 64'd1, 1'b0, 64'h0); #1;
      checks++; if (illegal_branch !== 1'b1 || take_branch !== 1'b0 || mispredict !== 1'b0)
         $display("FAIL illegal_outputs: got %0b/%0b/%0b want 1/0/0", illegal_branch, take_branch, mispredict); else passed++;
      step(); idle(); #1;
      checks++; if (illegal_branch !== 1'b0) $display("FAIL illegal_idle: got %0b want 0", illegal_branch); else passed++;
      checks++; if (branch_count !== 4'd12 || mispredict_count !== 4'd3)
         $display("FAIL illegal_counts: got %0d/%0d want 12/3", branch_count, mispredict_count); else passed++;
   endtask

   task automatic test_count_saturation();
      for (int k = 0; k < 13; k++) begin
         drive_branch(64'h40, 64'h8, 3'b000, 64'd3, 64'd3, 1'b0, 64'h0);
         step();
      end
      idle(); #1;
      checks++; if (branch_count !== 4'd15) $display("FAIL bcnt_saturate: got %0d want 15", branch_count); else passed++;
      checks++; if (mispredict_count !== 4'd15) $display("FAIL mcnt_saturate: got %0d want 15", mispredict_count); else passed++;
   endtask

   task automatic test_reset_mid();
      if_pc = 64'h200;
      drive_branch(64'h200, 64'h40, 3'b000, 64'd1, 64'd1, 1'b1, 64'h240);
      #2 reset = 1'b1; #1;
      checks++; if (branch_count !== 4'd0 || mispredict_count !== 4'd0)
         $display("FAIL rstmid_counts: got %0d/%0d want 0/0", branch_count, mispredict_count); else passed++;
      checks++; if (pred_taken !== 1'b0 || pred_target !== 64'h204)
         $display("FAIL rstmid_pred: got %0b/%h want 0/204", pred_taken, pred_target); else passed++;
      step(); idle(); reset = 1'b0; #1;
      checks++; if (pred_taken !== 1'b0) $display("FAIL rstmid_after: got %0b want 0", pred_taken); else passed++;
   endtask

   initial begin
      reset = 1'b1; if_pc = '0; res_valid = 1'b0; res_stall = 1'b0;
      res_pc = '0; res_imm = '0; res_funct3 = '0; rs1_data = '0; rs2_data = '0;
      res_pred_taken = 1'b0; res_pred_target = '0;
      step(); step();
      reset = 1'b0;
      test_reset();
      test_beq();
      test_compare();
      test_saturation();
      test_alias();
      test_stall();
      test_illegal();
      test_count_saturation();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
